// File: rtl/uart_pkg.sv
// Shared types and helpers for the button-triggered UART transmitter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Number of payload bits in a frame.
    localparam int DATA_BITS = 8;

    // Clock cycles per serial bit; integer division, caller must keep it >= 2.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser plus rising-edge detect for a slow-domain level input.
// Latency: a level first sampled high at edge k gives rise = 1 in the cycle after edge k+1.
// Backpressure: none; rise is a one-cycle pulse that is lost if the consumer ignores it.
module sync_rise (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    // Resync chain and delayed copy; reset to 1 so a level already high at reset release is not an edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_d <= 1'b1;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/uart_tx_button.sv
// Button-triggered UART transmitter: one frame of tx_data per button press; even parity when UART_TX_PARITY_EN is defined.
// Latency: send_req first sampled high at edge k drops tx and raises busy at edge k+2; frame is 10 (11 with parity) bit times.
// Backpressure: none; presses arriving while busy are dropped, a press landing in the first idle cycle after done is taken.
module uart_tx_button
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST     = 3'(DATA_BITS - 1);

    uart_state_t      state_q;
    uart_state_t      state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             trig;
    logic             bit_end;
    logic             load;
    logic             shift_en;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    sync_rise u_sync_rise (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (send_req),
        .rise     (trig)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and line outputs; tx/busy/done are decoded from state so reset clears them on the next edge.
    always_comb begin
        state_nxt = state_q;
        tx        = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (trig) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Baud counter, bit index and shift register; the byte is latched once so later tx_data changes are ignored.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (load) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q     <= ^tx_data;
`endif
        end else if (state_q != IDLE) begin
            cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            if (shift_en) begin
                shift_q   <= {1'b0, shift_q[7:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_button.sv
`timescale 1ns/1ps
module tb_uart_tx_button;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk_in   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_button #(
        .CLK_FREQ_HZ (16),
        .BAUD        (1)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .send_req (send_req),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference line level for frame bit k: start, D0..D7 LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Release the button, then press it; returns just before the cycle in which the frame should start.
    task automatic press(input logic [7:0] b);
        @(negedge clk_in);
        send_req = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("pre_busy", busy, 1'b0);
        tx_data  = b;
        send_req = 1'b1;
        @(negedge clk_in);
        chk("lat_k_busy", busy, 1'b0);
        @(negedge clk_in);
        chk("lat_k1_busy", busy, 1'b0);
        chk("lat_k1_tx", tx, 1'b1);
    endtask

    // Check every cycle of one frame. mode 1: re-press and change tx_data mid-frame;
    // mode 2: arrange a press whose trigger lands right after done; mode 3: pulse reset in bit D4.
    task automatic check_frame(input logic [7:0] b, input int mode, input logic [7:0] next_b);
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk_in);
            chk($sformatf("tx[%0d]", i), tx, frame_bit(b, i / CPB));
            chk($sformatf("busy[%0d]", i), busy, 1'b1);
            chk($sformatf("done[%0d]", i), done, (i == FRAME_CYC - 1));
            case (mode)
                1: begin
                    if (i == 20) begin
                        send_req = 1'b0;
                        tx_data  = 8'($urandom);
                    end
                    if (i == 40) send_req = 1'b1;
                    if (i == 60) tx_data = 8'hFF;
                end
                2: begin
                    if (i == 50) send_req = 1'b0;
                    if (i == FRAME_CYC - 2) begin
                        tx_data  = next_b;
                        send_req = 1'b1;
                    end
                end
                3: begin
                    if (i == 5 * CPB + 8) begin
                        rst_n = 1'b0;
                        @(negedge clk_in);
                        chk("rst_mid_tx", tx, 1'b1);
                        chk("rst_mid_busy", busy, 1'b0);
                        chk("rst_mid_done", done, 1'b0);
                        rst_n = 1'b1;
                        return;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b2;

        // Reset with the button held high, then keep it held: no frame may start.
        rst_n    = 1'b0;
        send_req = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_in);
            chk("held_tx", tx, 1'b1);
            chk("held_busy", busy, 1'b0);
        end

        // Fixed patterns, including the parity examples.
        press(8'h55);
        check_frame(8'h55, 0, 8'h00);
        @(negedge clk_in);
        chk("post_busy", busy, 1'b0);
        chk("post_done", done, 1'b0);
        press(8'h07);
        check_frame(8'h07, 0, 8'h00);

        // Random bytes with random idle gaps.
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            press(b);
            check_frame(b, 0, 8'h00);
            repeat ($urandom_range(0, 10)) @(negedge clk_in);
        end

        // Second press during DATA plus tx_data change: one frame of the original byte only.
        b = 8'($urandom);
        press(b);
        check_frame(b, 1, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            chk("drop_busy", busy, 1'b0);
            chk("drop_tx", tx, 1'b1);
        end

        // Back-to-back: trigger in the first idle cycle after done.
        b  = 8'($urandom);
        b2 = 8'($urandom);
        press(b);
        check_frame(b, 2, b2);
        @(negedge clk_in);
        chk("gap_busy", busy, 1'b0);
        chk("gap_tx", tx, 1'b1);
        check_frame(b2, 0, 8'h00);

        // Reset in the middle of D4, then a fresh press sends a complete frame.
        press(8'h5A);
        check_frame(8'h5A, 3, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            chk("after_rst_busy", busy, 1'b0);
        end
        b = 8'($urandom);
        press(b);
        check_frame(b, 0, 8'h00);
        @(negedge clk_in);
        chk("end_busy", busy, 1'b0);
        chk("end_tx", tx, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
